// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default widths/frame length, stage state enum, sign extension.
package fft_pkg;

    localparam int FFT_IN_W  = 8;
    localparam int FFT_OUT_W = FFT_IN_W + 1;
    localparam int FFT_N     = 32;
    localparam int FFT_HALF  = FFT_N / 2;
    localparam int FFT_CNT_W = $clog2(FFT_N);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sdf_state_e;

    // Treats the low w bits of raw as two's complement and returns the value.
    function automatic int sext(input logic [31:0] raw, input int w);
        int shifted;
        shifted = int'(raw << (32 - w));
        return shifted >>> (32 - w);
    endfunction

endpackage

// File: rtl/but_real.sv
// Real radix-2 butterfly: sum = a + b, diff = a - b; purely combinational, no flow control.
module but_real #(
    parameter int IN_W  = 9,
    parameter int OUT_W = 9
) (
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    output logic [OUT_W-1:0] sum,
    output logic [OUT_W-1:0] diff
);

    logic signed [OUT_W-1:0] a_s;
    logic signed [OUT_W-1:0] b_s;

    assign a_s  = OUT_W'(signed'(a));
    assign b_s  = OUT_W'(signed'(b));
    assign sum  = a_s + b_s;
    assign diff = a_s - b_s;

endmodule

// File: rtl/sdf_delay_line.sv
// DEPTH-entry shift register with enable and synchronous clear; dout is the oldest entry.
module sdf_delay_line #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (en) begin
            mem_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                mem_d[i] = mem_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/sdf_r2_stage.sv
// Radix-2 SDF stage: streams sums x[k]+x[k+N/2], recirculates differences into next frame's first half.
// Registered outputs, 1-cycle latency, no back-pressure; SDF_FLUSH_EN adds a flush-driven drain.
module sdf_r2_stage
    import fft_pkg::*;
#(
    parameter int IN_W  = FFT_IN_W,
    parameter int OUT_W = FFT_OUT_W,
    parameter int N     = FFT_N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
`ifdef SDF_FLUSH_EN
    input  logic             flush,
`endif
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sop
);

    localparam int HALF  = N / 2;
    localparam int CNT_W = $clog2(N);

    sdf_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_sop_q, out_sop_d;

    logic             dl_en;
    logic [OUT_W-1:0] dl_din;
    logic [OUT_W-1:0] dl_head;
    logic [OUT_W-1:0] in_ext;
    logic [OUT_W-1:0] bf_sum;
    logic [OUT_W-1:0] bf_diff;
    logic             phase_b;
    logic             flush_go;
    logic             run_go;

    assign in_ext  = OUT_W'(sext(32'(in_data), IN_W));
    assign phase_b = cnt_q[CNT_W-1];

`ifdef SDF_FLUSH_EN
    // A flush only lands on a frame boundary, so the delay line holds exactly one frame of differences.
    assign flush_go = (state_q == RUN) && flush && (cnt_q == '0);
`else
    assign flush_go = 1'b0;
`endif
    assign run_go = in_valid && !flush_go;

    but_real #(
        .IN_W  (OUT_W),
        .OUT_W (OUT_W)
    ) u_but (
        .a    (dl_head),
        .b    (in_ext),
        .sum  (bf_sum),
        .diff (bf_diff)
    );

    sdf_delay_line #(
        .W     (OUT_W),
        .DEPTH (HALF)
    ) u_dl (
        .clk  (clk),
        .clr  (rst),
        .en   (dl_en),
        .din  (dl_din),
        .dout (dl_head)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_data_d  = out_data_q;
        dl_en       = 1'b0;
        dl_din      = phase_b ? bf_diff : in_ext;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    dl_en = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(HALF - 1)) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
`ifdef SDF_FLUSH_EN
                if (flush_go) begin
                    state_d = DRAIN;
                end
`endif
                if (run_go) begin
                    dl_en       = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                    out_valid_d = 1'b1;
                    out_data_d  = phase_b ? bf_sum : dl_head;
                    out_sop_d   = (cnt_q == CNT_W'(HALF));
                end
            end
`ifdef SDF_FLUSH_EN
            DRAIN: begin
                // Shift zeros in so the line is empty again when FILL resumes.
                dl_en       = 1'b1;
                dl_din      = '0;
                out_valid_d = 1'b1;
                out_data_d  = dl_head;
                cnt_d       = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = FILL;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;

endmodule

// File: doc/sdf_r2_stage.md
# sdf_r2_stage

Radix-2 single-path delay-feedback (SDF) stage for the streaming real-valued FFT datapath. It takes one sample per valid cycle, buffers the first half of each N-point frame in a feedback delay line, and pairs each buffered sample x[n] with x[n+N/2] for the butterfly adder `but_real`. It streams out the sums immediately and recirculates the differences through the same delay line, emitting them during the first half of the next frame. It sits directly upstream of the next FFT stage and owns the sequencing that feeds the butterfly adder.

## Interface
- `IN_W`, 8, input sample width, signed two's complement
- `OUT_W`, 9, output width; must equal `IN_W+1`
- `N`, 32, frame length; power of two, ≥4; `HALF = N/2`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in_data` valid this cycle
- `in_data`  in  IN_W  signed input sample
- `flush`  in  1  drain request; present only with `SDF_FLUSH_EN`
- `out_valid`  out  1  `out_data` valid
- `out_data`  out  OUT_W  signed butterfly result
- `out_sop`  out  1  first output of a frame (first sum)

## Operation
- `cnt` is a log2(N)-bit sample counter.
  - Increments on each accepted sample (`in_valid`=1).
  - Wraps from N-1 to 0.
- The delay line holds `HALF` entries of `OUT_W` bits. It advances only on accepted samples; otherwise it holds.
- **Phase A** (`cnt < HALF`):
  - `in_data`, sign-extended to `OUT_W`, enters the delay line.
  - The delay-line head (a difference from the previous frame) is the output.
- **Phase B** (`cnt ≥ HALF`):
  - The head is x[n] and `in_data` is x[n+HALF].
  - Both feed `but_real`.
  - `out_p = x[n] + x[n+HALF]` is the output.
  - `out_n = x[n] − x[n+HALF]` enters the delay line.
- Arithmetic is exact in `OUT_W`. No saturation or rounding is needed because inputs are `IN_W` bits.
- **States:**
  - **FILL**: reset state; delay line not primed; outputs suppressed. Moves to RUN when a sample is accepted at `cnt == HALF−1`.
  - **RUN**: every accepted sample produces one output.
  - **DRAIN**: macro build only; see Configuration.
- Output order per frame:
  - HALF sums x[k]+x[k+HALF], k = 0..HALF−1.
  - Then HALF differences, emitted during phase A of the following frame.
- `out_sop` = 1 with the output produced by the accepted sample at `cnt == HALF` in RUN.
- Reset mid-operation:
  - `cnt` clears to 0 and the state returns to FILL.
  - Delay line clears to 0.
  - Pending differences are discarded.
  - `out_valid` is low from the cycle after `rst`.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_sop` = 0
  - `cnt` = 0, state = FILL, delay line all 0
- Outputs are registered: latency is 1 cycle from an accepted sample to its `out_valid`.
- `out_valid(t+1) = in_valid(t)` when in RUN, or when entering RUN on that sample's transition... precisely: the accepted sample at `cnt == HALF` of the first frame is the first to produce an output.
- Back-pressure is not supported. The downstream stage must accept every `out_valid` cycle.
- Gaps in `in_valid` stall the stage completely. No data is lost or reordered.
- `rst` takes priority over all other inputs, including `in_valid` and `flush`.

## Configuration
- `SDF_FLUSH_EN` defined:
  - Adds the `flush` input and the DRAIN state.
  - `flush` is honoured only in RUN with `cnt == 0`; at any other count it is ignored.
  - In DRAIN, the delay line advances every cycle with zero input and outputs `HALF` differences with `out_valid` = 1.
  - DRAIN then returns to FILL with `cnt` = 0.
  - `in_valid` during DRAIN is ignored; those samples are dropped.
- `SDF_FLUSH_EN` undefined:
  - No `flush` port and no DRAIN state.
  - The last frame's differences emerge only when the next frame is pushed.

## Structure
- A shared package `fft_pkg` holds:
  - the state enum (`FILL`, `RUN`, `DRAIN`)
  - the `N`/`HALF` and width constants
  - the sign-extension helper function
- Sub-module `sdf_delay_line`: a `HALF`-deep, `OUT_W`-wide shift register with enable and synchronous clear.
- The sum and difference come from an instantiated `but_real`, with widths `OUT_W`/`OUT_W`.

## Test plan
- **Reset:** `rst` 1 for 3 cycles, then 20 idle cycles → `out_valid` = 0, `out_data` = 0, `out_sop` = 0 throughout.
- **Ramp:** continuous ramp 0..31, then 32 zeros →
  - First `out_valid` arrives the cycle after sample 16, with `out_data` = 16 and `out_sop` = 1.
  - Then 18, 20, …, 46.
  - Then 16 outputs of −16 during the zero frame.
- **Extremes:**
  - Both halves −128 → sums −256, differences 0.
  - First half 127, second half −128 → sums −1, differences 255.
- **Gapped input:** the ramp frame with `in_valid` on alternate cycles → identical output sequence. Each `out_valid` arrives exactly 1 cycle after its sample.
- **Reset mid-frame:** `rst` at `cnt` = 20 during RUN, then a new ramp → no outputs until the new sample 16. The first value is 16 and no stale −16 appears.
- **Flush (`SDF_FLUSH_EN`):**
  - After one ramp frame, pulse `flush` at `cnt` = 0 → 16 consecutive cycles with `out_data` = −16, then `out_valid` = 0.
  - A `flush` pulse at `cnt` = 5 is ignored.
